// File: rtl/burst_seq_ctrl.sv
// burst_seq_ctrl
//   Sequencer for a bank of burst gate operators in the stochastic NN datapath.
//   A START request clears every gate with a one-cycle INIT pulse. It then
//   lets the gate memory fill for SETTLE discard cycles, and counts the ones
//   each lane produces over a LEN-cycle evaluation window. The per-lane counts
//   are reported with a START/DONE handshake.
//
// Parameters
//   NLANE   number of burst gate lanes
//   CNTW    width of LEN and of each lane counter
//   SETTLE  discard cycles between INIT and the counting window (0..15)
//
// Ports
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   START      request a new evaluation (only looked at in IDLE)
//   ABORT      drop the current evaluation and return to IDLE
//   LEN        evaluation window length, captured when START is accepted
//   BURST_OUT  registered OUT of each burst gate, bit i = lane i
//   GATE_INIT  broadcast INIT to all burst gates
//   GATE_EN    enable for the stream generators feeding the gates
//   BUSY       high whenever the sequencer is not idle
//   DONE       one-cycle pulse while CNT holds a finished result
//   CNT        packed lane counts, lane i at [i*CNTW +: CNTW]
module burst_seq_ctrl #(
  parameter int NLANE  = 4,
  parameter int CNTW   = 10,
  parameter int SETTLE = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic [CNTW-1:0]         LEN,
  input  logic [NLANE-1:0]        BURST_OUT,
  output logic                    GATE_INIT,
  output logic                    GATE_EN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [NLANE*CNTW-1:0]   CNT
);

  // The phase counter has to hold both SETTLE-1 (up to 14) and LEN-1.
  localparam int CYCW = (CNTW > 4) ? CNTW : 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SETTLE,
    S_RUN,
    S_FIN
  } state_e;

  state_e                  state_q, state_d;
  logic [CNTW-1:0]         len_q;
  logic [CYCW-1:0]         cyc_q;
  logic [NLANE*CNTW-1:0]   cnt_q;
  logic                    gateInit_q;
  logic                    gateEn_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    accept;
  logic                    abortRun;

  // Next-state decision. ABORT only matters once an evaluation is under way;
  // in IDLE it simply vetoes START. cyc_q counts down the cycles left in
  // the SETTLE and RUN phases, so reaching zero means this is the last
  // cycle of that phase.
  always_comb begin
    accept   = (state_q == S_IDLE) && START && !ABORT;
    abortRun = (state_q != S_IDLE) && ABORT;
    state_d  = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        if (SETTLE > 0)       state_d = S_SETTLE;
        else if (len_q != '0) state_d = S_RUN;
        else                  state_d = S_FIN;
      end
      S_SETTLE: begin
        if (cyc_q == '0) begin
          if (len_q != '0) state_d = S_RUN;
          else             state_d = S_FIN;
        end
      end
      S_RUN: begin
        if (cyc_q == '0) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abortRun) state_d = S_IDLE;
  end

  // State, phase counter, lane counters and outputs. The outputs are
  // decoded from the state being entered, so each one is a plain flop
  // that mirrors the current state with no input-to-output path.
  // The lane counters drive CNT directly. They are zeroed when a run is
  // accepted (so CNT reads 0 during CLEAR) and when a run is aborted.
  // They hold their value in IDLE after a normal finish.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      cyc_q      <= '0;
      cnt_q      <= '0;
      gateInit_q <= 1'b0;
      gateEn_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gateInit_q <= (state_d == S_CLEAR);
      gateEn_q   <= (state_d == S_SETTLE) || (state_d == S_RUN);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_FIN);

      if (accept) len_q <= LEN;

      if ((state_d == S_SETTLE) && (state_q != S_SETTLE)) begin
        cyc_q <= CYCW'(SETTLE - 1);
      end else if ((state_d == S_RUN) && (state_q != S_RUN)) begin
        cyc_q <= CYCW'(len_q) - CYCW'(1);
      end else if (cyc_q != '0) begin
        cyc_q <= cyc_q - CYCW'(1);
      end

      if (accept || abortRun) begin
        cnt_q <= '0;
      end else if (state_q == S_RUN) begin
        for (int i = 0; i < NLANE; i++) begin
          cnt_q[i*CNTW +: CNTW] <= cnt_q[i*CNTW +: CNTW] + CNTW'(BURST_OUT[i]);
        end
      end
    end
  end

  assign GATE_INIT = gateInit_q;
  assign GATE_EN   = gateEn_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign CNT       = cnt_q;

endmodule

// File: tb/tb_burst_seq_ctrl.sv
// tb_burst_seq_ctrl
//   Bench for burst_seq_ctrl. It keeps an edge-indexed reference model.
//   When a run is accepted at edge A, every later output follows from
//   the phase p = edge - A:
//     p == 0                       GATE_INIT
//     1 <= p <= SETTLE+LEN         GATE_EN
//     p == SETTLE+LEN+1            DONE
//     SETTLE+2 <= p <= SETTLE+LEN+1  edges on which BURST_OUT is counted
//   The bench combines a table of whole runs, hand-written corner-case
//   sequences and a randomized stretch.
module tb_burst_seq_ctrl;

  localparam int NLANE  = 4;
  localparam int CNTW   = 10;
  localparam int SETTLE = 2;

  logic                  CLK;
  logic                  RST_N;
  logic                  START;
  logic                  ABORT;
  logic [CNTW-1:0]       LEN;
  logic [NLANE-1:0]      BURST_OUT;
  logic                  GATE_INIT;
  logic                  GATE_EN;
  logic                  BUSY;
  logic                  DONE;
  logic [NLANE*CNTW-1:0] CNT;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int edgeNum = 0;
  bit mActive = 0;
  int mAcc    = 0;
  int mLen    = 0;
  int mCnt [NLANE];

  typedef struct {
    int                    len;
    logic [NLANE-1:0]      burst;
    logic [NLANE*CNTW-1:0] cnt;
    int                    lat;
  } runVec_t;

  runVec_t vecs [6];

  burst_seq_ctrl #(.NLANE(NLANE), .CNTW(CNTW), .SETTLE(SETTLE)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .ABORT     (ABORT),
    .LEN       (LEN),
    .BURST_OUT (BURST_OUT),
    .GATE_INIT (GATE_INIT),
    .GATE_EN   (GATE_EN),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .CNT       (CNT)
  );

  // Free-running 10-unit clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One comparison: count it and report it if it differs
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (edge %0d): got 0x%0h, expected 0x%0h", name, edgeNum, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input int len, input logic [NLANE-1:0] b);
    START     = s;
    ABORT     = a;
    LEN       = CNTW'(len);
    BURST_OUT = b;
  endtask

  task automatic modelReset();
    mActive = 0;
    for (int i = 0; i < NLANE; i++) mCnt[i] = 0;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge
  task automatic modelStep();
    int p;
    edgeNum++;
    if (!RST_N) begin
      modelReset();
    end else if (mActive) begin
      p = edgeNum - mAcc;
      if (ABORT) begin
        modelReset();
      end else begin
        if (p >= SETTLE + 2 && p <= SETTLE + mLen + 1)
          for (int i = 0; i < NLANE; i++) mCnt[i] += int'(BURST_OUT[i]);
        if (p == SETTLE + mLen + 2) mActive = 0;
      end
    end else if (START && !ABORT) begin
      modelReset();
      mActive = 1;
      mAcc    = edgeNum;
      mLen    = int'(LEN);
    end
  endtask

  // Compare every output against the model. CNT is compared only while it
  // is meant to hold a result, i.e. at DONE and while idle.
  task automatic compareAll();
    int                    p;
    logic                  eInit, eEn, eBusy, eDone;
    logic [NLANE*CNTW-1:0] eCnt;
    eInit = 0; eEn = 0; eBusy = 0; eDone = 0;
    if (mActive) begin
      p     = edgeNum - mAcc;
      eInit = (p == 0);
      eEn   = (p >= 1) && (p <= SETTLE + mLen);
      eDone = (p == SETTLE + mLen + 1);
      eBusy = 1;
    end
    for (int i = 0; i < NLANE; i++) eCnt[i*CNTW +: CNTW] = CNTW'(mCnt[i]);
    checkOutput("GATE_INIT", 64'(GATE_INIT), 64'(eInit));
    checkOutput("GATE_EN",   64'(GATE_EN),   64'(eEn));
    checkOutput("BUSY",      64'(BUSY),      64'(eBusy));
    checkOutput("DONE",      64'(DONE),      64'(eDone));
    if (!eBusy || eDone) checkOutput("CNT", 64'(CNT), 64'(eCnt));
  endtask

  task automatic tick();
    @(posedge CLK);
    modelStep();
    #1;
    compareAll();
  endtask

  // Issue one START and follow it to DONE, tallying the gate control pulses
  task automatic runOne(input int len, input logic [NLANE-1:0] b, output int lat,
                        output logic [NLANE*CNTW-1:0] cntAtDone, output int enCnt, output int initCnt);
    int limit;
    limit = len + SETTLE + 20;
    applyStimulus(1'b1, 1'b0, len, b);
    tick();
    START   = 1'b0;
    lat     = 1;
    enCnt   = int'(GATE_EN);
    initCnt = int'(GATE_INIT);
    while (!DONE && lat < limit) begin
      tick();
      lat++;
      enCnt   += int'(GATE_EN);
      initCnt += int'(GATE_INIT);
    end
    cntAtDone = CNT;
    tick();
  endtask

  initial begin
    int                    lat, enCnt, initCnt;
    logic [NLANE*CNTW-1:0] c;
    bit                    sawDone;

    vecs[0] = '{8,    4'b0101, {10'd0, 10'd8, 10'd0, 10'd8},    12};
    vecs[1] = '{0,    4'b1111, {10'd0, 10'd0, 10'd0, 10'd0},    4};
    vecs[2] = '{1,    4'b1111, {10'd1, 10'd1, 10'd1, 10'd1},    5};
    vecs[3] = '{5,    4'b1010, {10'd5, 10'd0, 10'd5, 10'd0},    9};
    vecs[4] = '{3,    4'b0110, {10'd0, 10'd3, 10'd3, 10'd0},    7};
    vecs[5] = '{1023, 4'b0001, {10'd0, 10'd0, 10'd0, 10'd1023}, 1027};

    // Reset held for three edges with START low
    modelReset();
    RST_N = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, '0);
    #1;
    compareAll();
    repeat (3) tick();
    RST_N = 1'b1;
    tick();

    // Table of complete runs
    for (int k = 0; k < 6; k++) begin
      runOne(vecs[k].len, vecs[k].burst, lat, c, enCnt, initCnt);
      checkOutput("runLatency", 64'(lat), 64'(vecs[k].lat));
      checkOutput("runCnt", 64'(c), 64'(vecs[k].cnt));
      checkOutput("runGateEnCycles", 64'(enCnt), 64'(SETTLE + vecs[k].len));
      checkOutput("runGateInitCycles", 64'(initCnt), 64'd1);
    end

    // Ones presented only while the gates settle must not be counted
    applyStimulus(1'b1, 1'b0, 5, 4'b1111);
    tick();
    START = 1'b0;
    repeat (3) tick();
    BURST_OUT = 4'b0000;
    sawDone = 0;
    for (int i = 0; i < 20 && !sawDone; i++) begin
      tick();
      sawDone = DONE;
    end
    checkOutput("settleDiscardDone", 64'(sawDone), 64'd1);
    checkOutput("settleDiscardCnt", 64'(CNT), 64'd0);
    tick();

    // Lane 2 alternating 1/0 across a six-cycle window
    applyStimulus(1'b1, 1'b0, 6, 4'b0000);
    tick();
    START = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 6; i++) begin
      BURST_OUT = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      tick();
    end
    BURST_OUT = 4'b0000;
    checkOutput("toggleDone", 64'(DONE), 64'd1);
    checkOutput("toggleCnt", 64'(CNT), 64'(40'd3 << 20));
    tick();

    // START while busy is ignored; ABORT drops the run with no DONE
    applyStimulus(1'b1, 1'b0, 20, 4'b1111);
    tick();
    START = 1'b0;
    repeat (3) tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    checkOutput("abortBusy", 64'(BUSY), 64'd0);
    checkOutput("abortDone", 64'(DONE), 64'd0);
    checkOutput("abortCnt", 64'(CNT), 64'd0);
    sawDone = 0;
    repeat (30) begin
      tick();
      if (DONE) sawDone = 1;
    end
    checkOutput("abortNoLateDone", 64'(sawDone), 64'd0);

    // START and ABORT together in IDLE: ABORT wins
    applyStimulus(1'b1, 1'b1, 4, 4'b1111);
    tick();
    applyStimulus(1'b0, 1'b0, 4, 4'b0000);
    checkOutput("startAbortIdle", 64'(BUSY), 64'd0);

    // Back-to-back runs: START held through DONE and into the following IDLE cycle
    applyStimulus(1'b1, 1'b0, 2, 4'b0011);
    repeat (12) tick();
    START = 1'b0;
    repeat (10) tick();

    // Asynchronous reset in the middle of RUN
    applyStimulus(1'b1, 1'b0, 10, 4'b1111);
    tick();
    START = 1'b0;
    repeat (6) tick();
    checkOutput("preResetBusy", 64'(BUSY), 64'd1);
    #3 RST_N = 1'b0;
    #1;
    checkOutput("asyncRstGateInit", 64'(GATE_INIT), 64'd0);
    checkOutput("asyncRstGateEn", 64'(GATE_EN), 64'd0);
    checkOutput("asyncRstBusy", 64'(BUSY), 64'd0);
    checkOutput("asyncRstDone", 64'(DONE), 64'd0);
    checkOutput("asyncRstCnt", 64'(CNT), 64'd0);
    modelReset();
    tick();
    RST_N = 1'b1;
    tick();
    runOne(3, 4'b1000, lat, c, enCnt, initCnt);
    checkOutput("postRstLatency", 64'(lat), 64'd7);
    checkOutput("postRstCnt", 64'(c), 64'(40'd3 << 30));

    // Randomized stretch against the model, with LEN wandering every cycle
    for (int i = 0; i < 2500; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 6)),
                    NLANE'($urandom));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 0, '0);
    repeat (80) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
